// File: rtl/afu_transpose_pp_if.sv
`default_nettype none
// ============================================================================
//  Module   : afu_transpose_pp_if
//  Purpose  : Valid/ready line-stream interface used on both sides of the
//             transposer. One instance carries the upstream line stream into
//             the block, a second carries the transposed stream out.
//  Ports    : valid - line qualifier, driven by the master
//             ready - sink can take the line, driven by the slave
//             data  - WIDTH-bit line, driven by the master
//  Modports : master (drives valid/data), slave (drives ready)
//  Revision : 1.0 - initial release
// ============================================================================
interface afu_transpose_pp_if #(
  parameter int WIDTH = 512
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input  ready);
  modport slave  (input  valid, input  data, output ready);
endinterface
`default_nettype wire

// File: rtl/afu_transpose_pp.sv
`default_nettype none
// ============================================================================
//  Module   : afu_transpose_pp
//  Purpose  : Streaming square-tile transposer with two ping-pong tile banks.
//             N = LINE_WIDTH/DATA_WIDTH lines are collected into one bank
//             while the other bank is emitted column by column, giving a
//             sustained rate of one line per cycle. A job of ctx_length lines
//             is started with a one-cycle start pulse; a trailing partial
//             tile is completed with zero rows before it is drained.
//  Ports    : clk        - clock
//             reset_n    - asynchronous active-low reset
//             start      - job start pulse (honoured only when idle)
//             ctx_length - number of input lines in the job
//             bypass     - (AFU_TRANSPOSE_BYPASS_EN only) pass lines through
//                          untransposed, sampled with start
//             in_if      - upstream line stream (slave)
//             out_if     - transposed line stream (master)
//             busy       - a job is in progress
//             done       - one-cycle pulse after the last output line
//  Options  : define AFU_TRANSPOSE_BYPASS_EN to add the bypass port.
//  Revision : 1.0 - initial release
// ============================================================================
module afu_transpose_pp #(
  parameter int LINE_WIDTH = 512,
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] ctx_length,
`ifdef AFU_TRANSPOSE_BYPASS_EN
  input  logic                 bypass,
`endif
  afu_transpose_pp_if.slave    in_if,
  afu_transpose_pp_if.master   out_if,
  output logic                 busy,
  output logic                 done
);

  localparam int N     = LINE_WIDTH / DATA_WIDTH;
  localparam int LOG2N = $clog2(N);
  localparam logic [LEN_WIDTH-1:0] TILE_MASK = LEN_WIDTH'(N - 1);
  localparam logic [LEN_WIDTH-1:0] ONE       = LEN_WIDTH'(1);

  typedef logic [LOG2N-1:0] idx_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAD    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t state, state_next;

  // Job bookkeeping
  logic [LEN_WIDTH-1:0] len;
  logic [LEN_WIDTH-1:0] total_out;
  logic [LEN_WIDTH-1:0] lines_in;
  logic [LEN_WIDTH-1:0] lines_out;
  logic [LEN_WIDTH-1:0] len_rounded;

  // Tile banks and their pointers
  logic [LINE_WIDTH-1:0] bank_mem [2][N];
  logic [1:0]            bank_full;
  logic [1:0]            bank_full_next;
  logic                  wb;
  logic                  rb;
  idx_t                  wr_row;
  idx_t                  ld_col;
  // Column N-1 of bank rb sits in the output register; the bank is released
  // when that line is accepted.
  logic                  tail;

  // Output register and bypass skid slot
  logic                  out_valid;
  logic [LINE_WIDTH-1:0] out_data;
  logic                  skid_valid;
  logic [LINE_WIDTH-1:0] skid_data;
  logic                  bypass_mode;

  // Combinational control
  logic                  in_ready;
  logic                  in_hs;
  logic                  out_fire;
  logic                  out_free;
  logic                  wr_en;
  logic                  wr_last;
  logic [LINE_WIDTH-1:0] wr_line;
  logic                  erb;
  logic                  fwd;
  logic                  src_avail;
  logic [LINE_WIDTH-1:0] col_line;
  logic                  load_en;
  logic [LINE_WIDTH-1:0] load_data;

  // --------------------------------------------------------------------------
  // Optional pass-through mode
  // --------------------------------------------------------------------------
`ifdef AFU_TRANSPOSE_BYPASS_EN
  logic bypass_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bypass_q <= 1'b0;
    end else if (state == S_IDLE && start) begin
      bypass_q <= bypass;
    end
  end

  assign bypass_mode = bypass_q;
`else
  assign bypass_mode = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Handshakes
  // --------------------------------------------------------------------------
  // in_ready is built from registered state only, so a bank released in this
  // cycle is seen by the write side one cycle later and out_ready never
  // reaches in_ready combinationally.
  always_comb begin
    if (bypass_mode) begin
      in_ready = (state == S_RUN) && (lines_in < len) && !skid_valid;
    end else begin
      in_ready = (state == S_RUN) && !bank_full[wb] && (lines_in < len);
    end
  end

  assign in_hs    = in_if.valid && in_ready;
  assign out_fire = out_valid && out_if.ready;
  assign out_free = !out_valid || out_if.ready;

  // Write side: real rows in RUN, zero rows while padding a partial tile.
  assign wr_en   = !bypass_mode && (in_hs || (state == S_PAD));
  assign wr_line = (state == S_PAD) ? '0 : in_if.data;
  assign wr_last = wr_en && (&wr_row);

  // Read side. tail together with a free output register implies the last
  // column of rb is leaving now, so the next load comes from the other bank.
  // A bank that is completing in this very cycle is read with its final row
  // taken straight from the write data, which gives the one-cycle latency
  // from the last row handshake to the first output line.
  assign erb       = tail ? ~rb : rb;
  assign fwd       = wr_last && (wb == erb) && !bank_full[erb];
  assign src_avail = bank_full[erb] || fwd;

  for (genvar j = 0; j < N; j++) begin : g_elem
    logic [LINE_WIDTH-1:0] row;
    if (j == N - 1) begin : g_fwd_row
      assign row = fwd ? wr_line : bank_mem[erb][j];
    end else begin : g_mem_row
      assign row = bank_mem[erb][j];
    end
    assign col_line[j*DATA_WIDTH +: DATA_WIDTH] = row[ld_col*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    load_en   = 1'b0;
    load_data = col_line;
    if (bypass_mode) begin
      // The skid slot is older than anything on the input, so it goes first.
      if (out_free && skid_valid) begin
        load_en   = 1'b1;
        load_data = skid_data;
      end else if (out_free && in_hs) begin
        load_en   = 1'b1;
        load_data = in_if.data;
      end
    end else if (out_free && src_avail) begin
      load_en = 1'b1;
    end
  end

  always_comb begin
    bank_full_next = bank_full;
    if (tail && out_fire) begin
      bank_full_next[rb] = 1'b0;
    end
    if (wr_last) begin
      bank_full_next[wb] = 1'b1;
    end
  end

  // total_out rounds the job up to a whole number of tiles.
  assign len_rounded = (ctx_length + TILE_MASK) & ~TILE_MASK;

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = (ctx_length == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (out_fire && (lines_out == total_out - ONE)) begin
          state_next = S_FINISH;
        end else if (!bypass_mode && in_hs && (lines_in == len - ONE) && !(&wr_row)) begin
          state_next = S_PAD;
        end
      end
      S_PAD: begin
        if (&wr_row) begin
          state_next = S_RUN;
        end
      end
      S_FINISH: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Job counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len       <= '0;
      total_out <= '0;
      lines_in  <= '0;
      lines_out <= '0;
    end else if (state == S_IDLE) begin
      if (start) begin
        len       <= ctx_length;
        total_out <= bypass_mode_at_start() ? ctx_length : len_rounded;
        lines_in  <= '0;
        lines_out <= '0;
      end
    end else begin
      if (in_hs) begin
        lines_in <= lines_in + ONE;
      end
      if (out_fire) begin
        lines_out <= lines_out + ONE;
      end
    end
  end

  // Mode that the job being started will run in.
  function automatic logic bypass_mode_at_start();
`ifdef AFU_TRANSPOSE_BYPASS_EN
    return bypass;
`else
    return 1'b0;
`endif
  endfunction

  // --------------------------------------------------------------------------
  // Tile banks
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < N; r++) begin
          bank_mem[b][r] <= '0;
        end
      end
      bank_full <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wr_row    <= '0;
      ld_col    <= '0;
      tail      <= 1'b0;
    end else begin
      bank_full <= bank_full_next;
      if (wr_en) begin
        bank_mem[wb][wr_row] <= wr_line;
        wr_row               <= wr_row + 1'b1;
        if (&wr_row) begin
          wb <= ~wb;
        end
      end
      if (!bypass_mode) begin
        if (tail && out_fire) begin
          rb <= ~rb;
        end
        if (load_en) begin
          ld_col <= ld_col + 1'b1;
        end
        tail <= load_en ? (&ld_col) : (tail && !out_fire);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output register and bypass skid slot
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
      done       <= 1'b0;
    end else begin
      if (load_en) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
      end else if (out_if.ready) begin
        out_valid <= 1'b0;
      end
      if (bypass_mode) begin
        if (in_hs && !out_free) begin
          skid_valid <= 1'b1;
          skid_data  <= in_if.data;
        end else if (out_free && skid_valid) begin
          skid_valid <= 1'b0;
        end
      end
      done <= (state == S_FINISH);
    end
  end

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = out_data;
  assign busy         = (state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_afu_transpose_pp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_afu_transpose_pp
//  Purpose  : Self-checking bench for afu_transpose_pp. Jobs are described in
//             a table; expected transposed lines are pushed to a scoreboard
//             when a job is launched and popped as the DUT emits them.
//             Reset, zero-length and mid-job reset are hand-written sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_afu_transpose_pp;

  localparam int LW   = 512;
  localparam int DW   = 16;
  localparam int LENW = 32;
  localparam int N    = LW / DW;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0;
  logic [LENW-1:0] ctx_length = '0;
  logic            busy;
  logic            done;
`ifdef AFU_TRANSPOSE_BYPASS_EN
  logic            bypass = 1'b0;
`endif

  always #5 clk = ~clk;

  afu_transpose_pp_if #(.WIDTH(LW)) in_if ();
  afu_transpose_pp_if #(.WIDTH(LW)) out_if ();

  afu_transpose_pp #(
    .LINE_WIDTH (LW),
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LENW)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .ctx_length (ctx_length),
`ifdef AFU_TRANSPOSE_BYPASS_EN
    .bypass     (bypass),
`endif
    .in_if      (in_if),
    .out_if     (out_if),
    .busy       (busy),
    .done       (done)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [LW-1:0] sb [$];

  typedef struct {
    int len;
    bit rnd_valid;
    bit rnd_ready;
    int stall;        // cycles with out_ready forced low at job start
    bit inject_start; // extra start pulse while busy
    int done_bound;   // latest cycle done may appear (0: unchecked)
    bit chk_cont;     // in_ready must never drop while lines remain
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Input line j, element i = {j[7:0], i[7:0]}
  function automatic logic [LW-1:0] mk_in(input int j);
    logic [LW-1:0] l;
    for (int i = 0; i < N; i++) l[i*DW +: DW] = {8'(j), 8'(i)};
    return l;
  endfunction

  // Output line c of tile t: element j is input line t*N+j element c, or 0
  // for rows beyond the job length.
  function automatic logic [LW-1:0] mk_out(input int len, input int t, input int c);
    logic [LW-1:0] l;
    for (int j = 0; j < N; j++) begin
      int g;
      g = t * N + j;
      l[j*DW +: DW] = (g < len) ? {8'(g), 8'(c)} : 16'h0000;
    end
    return l;
  endfunction

  task automatic push_expected(input int len);
    int tiles;
    tiles = (len + N - 1) / N;
    for (int t = 0; t < tiles; t++)
      for (int c = 0; c < N; c++)
        sb.push_back(mk_out(len, t, c));
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_job(input vec_t v);
    int sent, recv, iter, hs_last, first_ov, done_iter, expected, want_acc;
    bit dropped;
    sent = 0; recv = 0; hs_last = -1; first_ov = -1; done_iter = -1; dropped = 1'b0;
    expected = ((v.len + N - 1) / N) * N;
    sb.delete();
    push_expected(v.len);

    @(negedge clk);
    start = 1'b1;
    ctx_length = LENW'(v.len);
    for (iter = 1; iter <= 3000 && done_iter < 0; iter++) begin
      @(negedge clk);
      start = v.inject_start && (iter == 10);
      ctx_length = v.inject_start ? LENW'(5) : LENW'(v.len);
      in_if.valid = (sent < v.len) && (!v.rnd_valid || $urandom_range(3) != 0);
      in_if.data = mk_in(sent);
      out_if.ready = (iter > v.stall) && (!v.rnd_ready || $urandom_range(2) != 0);
      #1;
      if (v.stall > 0 && iter == v.stall) begin
        want_acc = (v.len < 2 * N) ? v.len : 2 * N;
        check("stall_accepted", 64'(sent), 64'(want_acc));
        check("stall_in_ready", in_if.ready, 1'b0);
        check("stall_out_valid", out_if.valid, 1'b1);
        if (sb.size() > 0) check_line("stall_hold", out_if.data, sb[0]);
      end
      if (v.chk_cont && sent < v.len && !in_if.ready) dropped = 1'b1;
      if (in_if.valid && in_if.ready) begin
        if (sent == N - 1) hs_last = iter;
        sent++;
      end
      if (out_if.valid && first_ov < 0) first_ov = iter;
      if (out_if.valid && out_if.ready) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 64'(recv), 64'(expected - 1));
        end else begin
          check_line("out_line", out_if.data, sb.pop_front());
        end
        recv++;
      end
      if (done) done_iter = iter;
    end
    in_if.valid = 1'b0;
    out_if.ready = 1'b0;
    start = 1'b0;

    check("done_seen", done_iter >= 0, 1'b1);
    check("in_count", 64'(sent), 64'(v.len));
    check("out_count", 64'(recv), 64'(expected));
    check("sb_empty", 64'(sb.size()), 64'd0);
    if (v.done_bound > 0) check("done_latency", done_iter <= v.done_bound, 1'b1);
    if (v.chk_cont) check("in_ready_cont", dropped, 1'b0);
    if (!v.rnd_valid && !v.rnd_ready && v.stall == 0 && v.len >= N)
      check("first_out_latency", 64'(first_ov), 64'(hs_last + 1));
    @(negedge clk);
    #1;
    check("done_pulse_end", done, 1'b0);
    check("idle_after_job", busy, 1'b0);
    if (done_iter < 0) begin
      apply_reset();
      sb.delete();
    end
  endtask

  initial begin
    vec_t rv;
    int sent;
    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;

    //            len rv rr stall inj bound cont
    vecs[0] = '{  32, 0, 0,   0,  0,  66,  0};  // basic tile
    vecs[1] = '{  96, 0, 0,   0,  0, 130,  1};  // continuous stream
    vecs[2] = '{  96, 0, 0, 100,  0,   0,  0};  // backpressure
    vecs[3] = '{  40, 1, 1,   0,  0,   0,  0};  // partial tile
    vecs[4] = '{  64, 0, 1,   0,  1,   0,  0};  // start while busy
    vecs[5] = '{   1, 0, 0,   0,  0,   0,  0};  // single line
    vecs[6] = '{  33, 1, 1,   0,  0,   0,  0};  // one row past a tile

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready", in_if.ready, 1'b0);
    check("rst_out_valid", out_if.valid, 1'b0);
    check_line("rst_out_data", out_if.data, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // in_valid while idle is ignored
    in_if.valid = 1'b1;
    in_if.data = mk_in(7);
    repeat (3) @(negedge clk);
    #1;
    check("idle_in_ready", in_if.ready, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_out_valid", out_if.valid, 1'b0);
    in_if.valid = 1'b0;

    // Zero-length job
    @(negedge clk);
    start = 1'b1;
    ctx_length = '0;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("zl_done_c1", done, 1'b0);
    check("zl_busy_c1", busy, 1'b1);
    @(negedge clk);
    #1;
    check("zl_done_c2", done, 1'b1);
    check("zl_out_valid", out_if.valid, 1'b0);
    @(negedge clk);
    #1;
    check("zl_done_c3", done, 1'b0);

    // Table-driven jobs
    for (int k = 0; k < 7; k++) run_job(vecs[k]);

    // Reset after 20 lines of the first tile
    out_if.ready = 1'b1;
    sent = 0;
    @(negedge clk);
    start = 1'b1;
    ctx_length = LENW'(32);
    for (int it = 0; it < 200 && sent < 20; it++) begin
      @(negedge clk);
      start = 1'b0;
      in_if.valid = 1'b1;
      in_if.data = mk_in(sent);
      #1;
      if (in_if.valid && in_if.ready) sent++;
    end
    check("mid_lines_fed", 64'(sent), 64'd20);
    @(negedge clk);
    reset_n = 1'b0;
    in_if.valid = 1'b0;
    #1;
    check("mid_rst_out_valid", out_if.valid, 1'b0);
    check("mid_rst_in_ready", in_if.ready, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    out_if.ready = 1'b0;
    rv = '{32, 0, 0, 0, 0, 66, 0};
    run_job(rv);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
